// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the two-requester mux arbiter.
// Holds the grant FSM state encoding and the mux select values.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// mux_arb_hold_cnt: saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr (zero next cycle), cnt (current count).
module mux_arb_hold_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_V) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin two-requester arbiter with grant hold that drives the
// shared 2:1 mux select and registers the winner's data onto out_data/out_valid.
// Ports: clk, rst (sync, active-high); req_a/a_data, req_b/b_data (requesters);
// gnt_a, gnt_b, sel (registered grant/select); out_data, out_valid (registered output).
// Optional anti-starvation hold limit enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a_data,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b_data,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    arb_state_t       state_d, state_q;
    logic             last_d, last_q;
    logic             sel_d, sel_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             expired;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    // The count is the number of grant cycles already completed, so the
    // current cycle is cycle cnt+1; the limit is hit one count early.
    localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;
    logic          hold_clr;

    assign hold_clr = (state_d != state_q) || (state_q == IDLE);
    assign expired  = (hold_cnt >= LIM);

    mux_arb_hold_cnt #(
        .MAX (MAX_HOLD),
        .W   (CW)
    ) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .cnt (hold_cnt)
    );
`else
    assign expired = 1'b0;
`endif

    assign gnt_a = (state_q == GRANT_A);
    assign gnt_b = (state_q == GRANT_B);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_q == SEL_A) ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    state_d = GRANT_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!req_a || (expired && req_b)) begin
                    state_d = req_b ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (!req_b || (expired && req_a)) begin
                    state_d = req_a ? GRANT_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last tracks the most recent grantee; sel does the same but keeps its
    // reset value of A until the first grant, and both hold through IDLE.
    always_comb begin
        last_d = last_q;
        sel_d  = sel_q;
        unique case (state_d)
            GRANT_A: begin
                last_d = SEL_A;
                sel_d  = SEL_A;
            end
            GRANT_B: begin
                last_d = SEL_B;
                sel_d  = SEL_B;
            end
            default: ;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (1'b1)
            (gnt_a && req_a): begin
                data_d  = a_data;
                valid_d = 1'b1;
            end
            (gnt_b && req_b): begin
                data_d  = b_data;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SEL_B;
            sel_q   <= SEL_A;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed stimulus, cycle-level reference model of the
// arbitration rules, and literal expectations for the key scenarios.
module tb_mux_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic [W-1:0] a_data = '0;
    logic [W-1:0] b_data = '0;
    logic         gnt_a, gnt_b, sel, out_valid;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    mux_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .a_data    (a_data),
        .req_b     (req_b),
        .b_data    (b_data),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, run = cycles the owner has shown.
    int           m_own  = 0;
    int           m_last = 2;
    int           m_run  = 0;
    bit           m_sel  = 1'b0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data = '0;

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_own = 0; m_last = 2; m_run = 0;
            m_sel = 1'b0; m_valid = 1'b0; m_data = '0;
        end else begin
            if (m_own == 1 && req_a) begin
                m_valid = 1'b1; m_data = a_data;
            end else if (m_own == 2 && req_b) begin
                m_valid = 1'b1; m_data = b_data;
            end else begin
                m_valid = 1'b0;
            end
            nxt = m_own;
            if (m_own == 0) begin
                if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else if (m_own == 1) begin
                if (!req_a || (TO_EN && m_run >= MH && req_b)) nxt = req_b ? 2 : 0;
            end else begin
                if (!req_b || (TO_EN && m_run >= MH && req_a)) nxt = req_a ? 1 : 0;
            end
            if (nxt != 0 && nxt == m_own) m_run++;
            else m_run = (nxt != 0) ? 1 : 0;
            if (nxt != 0) m_last = nxt;
            if (nxt == 1) m_sel = 1'b0;
            if (nxt == 2) m_sel = 1'b1;
            m_own = nxt;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_gnt_a", gnt_a, m_own == 1);
            chk("m_gnt_b", gnt_b, m_own == 2);
            chk("m_sel", sel, m_sel);
            chk("m_valid", out_valid, m_valid);
            chk("m_data", out_data, m_data);
        end
    end

    task automatic drive(input bit r, input bit ra, input bit rb,
                         input logic [W-1:0] da, input logic [W-1:0] db);
        rst = r; req_a = ra; req_b = rb; a_data = da; b_data = db;
        @(negedge clk);
    endtask

    task automatic lit_outs(input string nm, input bit ga, input bit gb,
                            input bit s, input bit v, input logic [W-1:0] d);
        chk({nm, "_gnt_a"}, gnt_a, ga);
        chk({nm, "_gnt_b"}, gnt_b, gb);
        chk({nm, "_sel"}, sel, s);
        chk({nm, "_valid"}, out_valid, v);
        chk({nm, "_data"}, out_data, d);
    endtask

    initial begin
        @(negedge clk);
        // reset with both requesting
        drive(1, 1, 1, 8'h00, 8'h00);
        started = 1'b1;
        lit_outs("rst1", 0, 0, 0, 0, 8'h00);
        drive(1, 1, 1, 8'h00, 8'h00);
        lit_outs("rst2", 0, 0, 0, 0, 8'h00);
        // first tie goes to A
        drive(0, 1, 1, 8'h11, 8'h22);
        lit_outs("first", 1, 0, 0, 0, 8'h00);
        // round robin through idle gaps
        drive(0, 0, 0, 8'h00, 8'h00);
        lit_outs("rr_idle1", 0, 0, 0, 0, 8'h00);
        drive(0, 1, 1, 8'h12, 8'h23);
        lit_outs("rr_b1", 0, 1, 1, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        lit_outs("rr_idle2", 0, 0, 1, 0, 8'h00);
        drive(0, 1, 1, 8'h13, 8'h24);
        lit_outs("rr_a2", 1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 1, 8'h14, 8'h25);
        lit_outs("rr_b2", 0, 1, 1, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        // single requester A, 3 cycles
        drive(0, 1, 0, 8'h3C, 8'h00);
        lit_outs("single1", 1, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 8'h3C, 8'h00);
        lit_outs("single2", 1, 0, 0, 1, 8'h3C);
        drive(0, 1, 0, 8'h3C, 8'h00);
        lit_outs("single3", 1, 0, 0, 1, 8'h3C);
        drive(0, 0, 0, 8'h00, 8'h00);
        lit_outs("release", 0, 0, 0, 0, 8'h3C);
        // direct handoff A -> B
        drive(0, 1, 0, 8'h55, 8'h00);
        lit_outs("ho_a", 1, 0, 0, 0, 8'h3C);
        drive(0, 0, 1, 8'h55, 8'hA5);
        lit_outs("ho_edge", 0, 1, 1, 0, 8'h3C);
        drive(0, 0, 1, 8'h00, 8'hA5);
        lit_outs("ho_data", 0, 1, 1, 1, 8'hA5);
        // reset mid-grant
        drive(1, 0, 1, 8'h00, 8'hA5);
        lit_outs("rst_mid", 0, 0, 0, 0, 8'h00);
        // both held high: hold limit or indefinite A grant
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 1, W'(k), W'(8'h80 | k));
            chk("hold_gnt_a", gnt_a, TO_EN ? (((k - 1) / MH) % 2 == 0) : 1'b1);
        end
        // mixed request pattern, checked by the model
        for (int i = 0; i < 30; i++) begin
            drive(0, (i % 3) != 0, (i % 5) < 3, W'(i * 13), W'(i * 29));
        end
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
